// File: rtl/input_irq_controller.sv
// ---------------------------------------------------------------------------
// input_irq_controller
//
// Peripheral-side end of the CPU input-interrupt handshake. Words from an
// external input device are buffered in a small show-ahead FIFO. While words
// are waiting, a request (InputRecv) is raised toward the control state
// machine. The control unit acknowledges with InputRst during exception
// entry. The exception handler then drains the FIFO through a
// memory-mapped read strobe (RdEn).
//
// Ports:
//   CLK        in   rising-edge clock
//   Reset      in   asynchronous, active-high reset
//   DevData    in   [DATA_W] word from the input device
//   DevValid   in   single-cycle strobe, DevData valid this cycle
//   DevReady   out  FIFO not full
//   KernelMode in   1 masks InputRecv (state is left untouched)
//   InputRst   in   acknowledge level from the control unit
//   RdEn       in   handler pop strobe
//   RdData     out  [DATA_W] head-of-FIFO word, 0 when empty
//   Count      out  [PTR_W+1] number of buffered words, 0..DEPTH
//   Overrun    out  sticky flag: a word was dropped on a full FIFO
//   OverrunClr in   clears Overrun (a simultaneous drop wins)
//   InputRecv  out  interrupt request to the control unit
// ---------------------------------------------------------------------------
module input_irq_controller #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [DATA_W-1:0] DevData,
    input  logic              DevValid,
    output logic              DevReady,
    input  logic              KernelMode,
    input  logic              InputRst,
    input  logic              RdEn,
    output logic [DATA_W-1:0] RdData,
    output logic [PTR_W:0]    Count,
    output logic              Overrun,
    input  logic              OverrunClr,
    output logic              InputRecv
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACK     = 2'd2
    } state_t;

    state_t            stateReg;
    state_t            stateNext;
    logic [DATA_W-1:0] memReg [DEPTH];
    logic [PTR_W-1:0]  wrPtrReg;
    logic [PTR_W-1:0]  rdPtrReg;
    logic [PTR_W:0]    countReg;
    logic [PTR_W:0]    countNext;
    logic              overrunReg;

    logic isEmpty;
    logic isFull;
    logic doPop;
    logic doPush;
    logic doDrop;

    assign isEmpty = (countReg == '0);
    assign isFull  = (countReg == FULL_COUNT);

    // A pop on the same edge frees a slot, so a full FIFO still accepts the
    // incoming word when the handler is reading at the same time.
    assign doPop  = RdEn & ~isEmpty;
    assign doPush = DevValid & (~isFull | doPop);
    assign doDrop = DevValid & isFull & ~doPop;

    always_comb begin
        countNext = countReg;
        if (doPush && !doPop) begin
            countNext = countReg + COUNT_ONE;
        end else if (doPop && !doPush) begin
            countNext = countReg - COUNT_ONE;
        end
    end

    // Storage carries no reset: stale entries are never visible because
    // RdData is forced to zero whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (doPush) begin
            memReg[wrPtrReg] <= DevData;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            wrPtrReg   <= '0;
            rdPtrReg   <= '0;
            countReg   <= '0;
            overrunReg <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + PTR_ONE;
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + PTR_ONE;
            end
            countReg <= countNext;
            if (doDrop) begin
                overrunReg <= 1'b1;
            end else if (OverrunClr) begin
                overrunReg <= 1'b0;
            end
        end
    end

    // Request state machine. It looks at the registered Count only, so a
    // word pushed at edge k raises the request from edge k+1.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: begin
                if (!isEmpty && !InputRst) begin
                    stateNext = PENDING;
                end
            end
            PENDING: begin
                if (InputRst) begin
                    stateNext = ACK;
                end else if (isEmpty) begin
                    stateNext = IDLE;
                end
            end
            ACK: begin
                if (!InputRst) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    assign RdData    = isEmpty ? '0 : memReg[rdPtrReg];
    assign DevReady  = ~isFull;
    assign Count     = countReg;
    assign Overrun   = overrunReg;
    assign InputRecv = (stateReg == PENDING) & ~KernelMode;

endmodule

// File: tb/tb_input_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_input_irq_controller
//
// Directed scenarios followed by randomized traffic. Each stimulus cycle
// advances a behavioural model (a word queue plus a request status) and
// queues the outputs the DUT should show after that clock edge. A separate
// monitor pops one expectation per edge (or per asynchronous reset pulse)
// and compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_input_irq_controller;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int PTR_W  = 2;

    localparam int REQ_NONE    = 0;
    localparam int REQ_RAISED  = 1;
    localparam int REQ_HANDLED = 2;

    logic              CLK        = 1'b0;
    logic              Reset      = 1'b1;
    logic [DATA_W-1:0] DevData    = '0;
    logic              DevValid   = 1'b0;
    logic              KernelMode = 1'b0;
    logic              InputRst   = 1'b0;
    logic              RdEn       = 1'b0;
    logic              OverrunClr = 1'b0;
    logic              DevReady;
    logic [DATA_W-1:0] RdData;
    logic [PTR_W:0]    Count;
    logic              Overrun;
    logic              InputRecv;

    input_irq_controller #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .DevData   (DevData),
        .DevValid  (DevValid),
        .DevReady  (DevReady),
        .KernelMode(KernelMode),
        .InputRst  (InputRst),
        .RdEn      (RdEn),
        .RdData    (RdData),
        .Count     (Count),
        .Overrun   (Overrun),
        .OverrunClr(OverrunClr),
        .InputRecv (InputRecv)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        int          count;
        logic [15:0] data;
        bit          ready;
        bit          ov;
        bit          recv;
    } exp_t;

    exp_t        expQ[$];
    logic [15:0] mWords[$];
    int          mReq = REQ_NONE;
    bit          mOv  = 1'b0;
    int          compared   = 0;
    int          mismatched = 0;
    event        rstChk;

    // Expected outputs from the model's current contents and the inputs
    // being driven now (KernelMode masks the request combinationally).
    function automatic exp_t snapshot(string tag);
        exp_t e;
        e.tag   = tag;
        e.count = mWords.size();
        e.data  = (mWords.size() > 0) ? mWords[0] : 16'h0000;
        e.ready = (mWords.size() < DEPTH);
        e.ov    = mOv;
        e.recv  = (mReq == REQ_RAISED) && !KernelMode;
        return e;
    endfunction

    // One clock edge of the behavioural model, using the inputs being driven.
    task automatic modelEdge();
        int n;
        bit popOk;
        bit dropped;
        n       = mWords.size();
        popOk   = RdEn && (n > 0);
        dropped = DevValid && (n == DEPTH) && !popOk;
        if (mReq == REQ_NONE) begin
            if (n > 0 && !InputRst) mReq = REQ_RAISED;
        end else if (mReq == REQ_RAISED) begin
            if (InputRst) mReq = REQ_HANDLED;
            else if (n == 0) mReq = REQ_NONE;
        end else begin
            if (!InputRst) mReq = REQ_NONE;
        end
        if (popOk) void'(mWords.pop_front());
        if (DevValid && !dropped) mWords.push_back(DevData);
        if (dropped) mOv = 1'b1;
        else if (OverrunClr) mOv = 1'b0;
    endtask

    // Called between edges: drive inputs, predict, then wait for the next
    // falling edge.
    task automatic cycle(input string tag, input bit dv, input logic [15:0] dd,
                         input bit rd, input bit ir, input bit km, input bit oc);
        DevValid   = dv;
        DevData    = dd;
        RdEn       = rd;
        InputRst   = ir;
        KernelMode = km;
        OverrunClr = oc;
        modelEdge();
        expQ.push_back(snapshot(tag));
        @(negedge CLK);
    endtask

    // Short asynchronous reset pulse away from any rising edge.
    task automatic resetPulse(input string tag);
        Reset      = 1'b1;
        DevValid   = 1'b0;
        DevData    = '0;
        RdEn       = 1'b0;
        InputRst   = 1'b0;
        KernelMode = 1'b0;
        OverrunClr = 1'b0;
        mWords.delete();
        mReq = REQ_NONE;
        mOv  = 1'b0;
        expQ.push_back(snapshot(tag));
        -> rstChk;
        #2;
        Reset = 1'b0;
    endtask

    task automatic check(input string tag, input string name,
                         input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s.%s actual=%0h required=%0h", tag, name, act, req);
        end
    endtask

    // Monitor: one expectation per rising edge or reset pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK or rstChk);
            #1;
            if (expQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL scoreboard_empty actual=0 required=1");
            end else begin
                e = expQ.pop_front();
                check(e.tag, "Count",     32'(Count),     32'(e.count));
                check(e.tag, "RdData",    32'(RdData),    32'(e.data));
                check(e.tag, "DevReady",  32'(DevReady),  32'(e.ready));
                check(e.tag, "Overrun",   32'(Overrun),   32'(e.ov));
                check(e.tag, "InputRecv", 32'(InputRecv), 32'(e.recv));
                $display("txn %-10s Count=%0d RdData=%04h Ready=%0b Ovr=%0b Recv=%0b",
                         e.tag, Count, RdData, DevReady, Overrun, InputRecv);
            end
        end
    end

    initial begin
        bit irL;
        bit kmL;
        irL = 1'b0;
        kmL = 1'b0;
        #1;
        resetPulse("init_rst");

        // First word and request latency.
        cycle("t1_push", 1, 16'hA5A5, 0, 0, 0, 0);
        cycle("t1_req",  0, 16'h0000, 0, 0, 0, 0);

        // Acknowledge, then poll the word out.
        cycle("t2_ack1", 0, 16'h0000, 0, 1, 0, 0);
        cycle("t2_ack2", 0, 16'h0000, 0, 1, 0, 0);
        cycle("t2_pop",  0, 16'h0000, 1, 0, 0, 0);
        cycle("t2_idle", 0, 16'h0000, 0, 0, 0, 0);
        cycle("t2_idle", 0, 16'h0000, 0, 0, 0, 0);

        // Re-arm after acknowledge while words remain.
        cycle("t3_push", 1, 16'h0001, 0, 0, 0, 0);
        cycle("t3_push", 1, 16'h0002, 0, 0, 0, 0);
        cycle("t3_push", 1, 16'h0003, 0, 0, 0, 0);
        cycle("t3_ack",  0, 16'h0000, 0, 1, 0, 0);
        cycle("t3_pop",  0, 16'h0000, 1, 1, 0, 0);
        cycle("t3_rel",  0, 16'h0000, 0, 0, 0, 0);
        cycle("t3_rearm",0, 16'h0000, 0, 0, 0, 0);
        cycle("t3_drain",0, 16'h0000, 1, 0, 0, 0);
        cycle("t3_drain",0, 16'h0000, 1, 0, 0, 0);
        cycle("t3_idle", 0, 16'h0000, 0, 0, 0, 0);

        // Overflow, full push+pop, ordering and overrun clear.
        for (int i = 1; i <= 5; i++) begin
            cycle("t4_fill", 1, 16'(i), 0, 0, 0, 0);
        end
        cycle("t4_pushpop", 1, 16'h0006, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle("t4_pop", 0, 16'h0000, 1, 0, 0, 0);
        end
        cycle("t4_clr",  0, 16'h0000, 0, 0, 0, 1);
        cycle("t4_idle", 0, 16'h0000, 0, 0, 0, 0);

        // Masking and empty read.
        cycle("t5_push",  1, 16'h0BEE, 0, 0, 0, 0);
        cycle("t5_req",   0, 16'h0000, 0, 0, 0, 0);
        cycle("t5_mask",  0, 16'h0000, 0, 0, 1, 0);
        cycle("t5_mask",  0, 16'h0000, 0, 0, 1, 0);
        cycle("t5_unmask",0, 16'h0000, 0, 0, 0, 0);
        cycle("t5_pop",   0, 16'h0000, 1, 0, 0, 0);
        cycle("t5_rdempty",0,16'h0000, 1, 0, 0, 0);
        cycle("t5_idle",  0, 16'h0000, 0, 0, 0, 0);

        // Asynchronous reset while acknowledged with words buffered.
        cycle("t6_push", 1, 16'h0011, 0, 0, 0, 0);
        cycle("t6_push", 1, 16'h0022, 0, 0, 0, 0);
        cycle("t6_push", 1, 16'h0033, 0, 0, 0, 0);
        cycle("t6_ack",  0, 16'h0000, 0, 1, 0, 0);
        resetPulse("t6_rst");
        for (int i = 0; i < 3; i++) begin
            cycle("t6_after", 0, 16'h0000, 0, 0, 0, 0);
        end

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                resetPulse("rnd_rst");
                irL = 1'b0;
                kmL = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) irL = ~irL;
            if ($urandom_range(0, 9) == 0) kmL = ~kmL;
            cycle("rnd",
                  ($urandom_range(0, 1) == 1),
                  16'($urandom),
                  ($urandom_range(0, 2) == 0),
                  irL, kmL,
                  ($urandom_range(0, 9) == 0));
        end

        compared++;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", expQ.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
